// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RISC-V immediate decoder feeding a 2-entry skid FIFO.
// Decode happens at the input; each entry carries its instruction and decoded fields.
module imm_decode_pipe #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_C = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_is_c,
    output logic            out_illegal
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            is_c;
        logic            illegal;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t          state_q, state_d;
    entry_t          head_q, head_d, tail_q, tail_d, dec;
    logic            in_ready_q, push, pop;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic [XLEN-1:0] imm_ci, imm_clui, imm_cj, imm_cb, imm_cls;
    assign imm_i    = XLEN'($signed(in_instr[31:20]));
    assign imm_s    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_z    = XLEN'(in_instr[19:15]);
    assign imm_ci   = XLEN'($signed({in_instr[12], in_instr[6:2]}));
    assign imm_clui = XLEN'($signed({in_instr[12], in_instr[6:2], 12'b0}));
    assign imm_cj   = XLEN'($signed({in_instr[12], in_instr[8], in_instr[10:9], in_instr[6], in_instr[7],
                                     in_instr[2], in_instr[11], in_instr[5:3], 1'b0}));
    assign imm_cb   = XLEN'($signed({in_instr[12], in_instr[6:5], in_instr[2], in_instr[11:10], in_instr[4:3], 1'b0}));
    assign imm_cls  = XLEN'({in_instr[5], in_instr[12:10], in_instr[6], 2'b00});
    // Unmatched encodings fall through with fmt 0, imm 0 and illegal set.
    always_comb begin
        dec         = '0;
        dec.instr   = in_instr;
        dec.illegal = 1'b1;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: {dec.fmt, dec.imm, dec.illegal} = {3'd1, imm_i, 1'b0};
                7'b0011011: if (XLEN == 64) {dec.fmt, dec.imm, dec.illegal} = {3'd1, imm_i, 1'b0};
                7'b0100011: {dec.fmt, dec.imm, dec.illegal} = {3'd2, imm_s, 1'b0};
                7'b1100011: {dec.fmt, dec.imm, dec.illegal} = {3'd3, imm_b, 1'b0};
                7'b0110111, 7'b0010111: {dec.fmt, dec.imm, dec.illegal} = {3'd4, imm_u, 1'b0};
                7'b1101111: {dec.fmt, dec.imm, dec.illegal} = {3'd5, imm_j, 1'b0};
                7'b1110011: {dec.fmt, dec.imm, dec.illegal} = in_instr[14] ? {3'd6, imm_z, 1'b0} : {3'd1, imm_i, 1'b0};
                default: ;
            endcase
        end else if (ENABLE_C) begin
            dec.is_c = 1'b1;
            if (in_instr[15:0] != 16'h0) begin
                case ({in_instr[15:13], in_instr[1:0]})
                    5'b000_01, 5'b010_01: {dec.fmt, dec.imm, dec.illegal} = {3'd1, imm_ci, 1'b0};
                    5'b011_01: if (in_instr[11:7] != 5'd0 && in_instr[11:7] != 5'd2)
                        {dec.fmt, dec.imm, dec.illegal} = {3'd4, imm_clui, 1'b0};
                    5'b101_01: {dec.fmt, dec.imm, dec.illegal} = {3'd5, imm_cj, 1'b0};
                    5'b110_01, 5'b111_01: {dec.fmt, dec.imm, dec.illegal} = {3'd3, imm_cb, 1'b0};
                    5'b010_00: {dec.fmt, dec.imm, dec.illegal} = {3'd1, imm_cls, 1'b0};
                    5'b110_00: {dec.fmt, dec.imm, dec.illegal} = {3'd2, imm_cls, 1'b0};
                    default: ;
                endcase
            end
        end
    end
    assign push = in_valid && in_ready_q;
    assign pop  = (state_q != EMPTY) && out_ready;
    // Head only changes on a pop or a push into an empty buffer, so outputs hold under stall.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        state_d = state_q;
        if (flush) state_d = EMPTY;
        else begin
            case (state_q)
                EMPTY: if (push) {head_d, state_d} = {dec, ONE};
                ONE: begin
                    if (push && pop) head_d = dec;
                    else if (push) {tail_d, state_d} = {dec, FULL};
                    else if (pop) state_d = EMPTY;
                end
                FULL: if (pop) {head_d, state_d} = {tail_q, ONE};
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != FULL);
        end
    end
    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_instr   = head_q.instr;
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_is_c    = head_q.is_c;
    assign out_illegal = head_q.illegal;
endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe: two configurations (32-bit with RVC, 64-bit without) driven in lockstep
// and checked against an arithmetic decode model plus a queue-based FIFO model.
module tb_imm_decode_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic        a_ready, a_valid, a_isc, a_ill, b_ready, b_valid, b_isc, b_ill;
    logic [31:0] a_instr, a_imm, b_instr;
    logic [63:0] b_imm;
    logic [2:0]  a_fmt, b_fmt;
    int          checks = 0, errors = 0;
    logic [31:0] q[$];

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        isc;
        logic        ill;
    } exp_t;

    imm_decode_pipe #(.XLEN(32), .ENABLE_C(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
        .in_instr(in_instr), .out_valid(a_valid), .out_ready(out_ready), .out_instr(a_instr),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_is_c(a_isc), .out_illegal(a_ill));
    imm_decode_pipe #(.XLEN(64), .ENABLE_C(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
        .in_instr(in_instr), .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_is_c(b_isc), .out_illegal(b_ill));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic longint u(input logic [31:0] x);
        return longint'({32'b0, x});
    endfunction

    function automatic longint sx(input longint v, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (v >= half) ? v - 2 * half : v;
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] w, input bit x64, input bit en_c);
        exp_t   e;
        longint v = 0;
        int     f = 0;
        longint i_imm = sx(u(w[31:20]), 12);
        e.isc = 1'b0;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h13, 7'h03, 7'h67: begin f = 1; v = i_imm; end
                7'h1b: if (x64) begin f = 1; v = i_imm; end
                7'h23: begin f = 2; v = sx(u(w[31:25]) * 32 + u(w[11:7]), 12); end
                7'h63: begin f = 3; v = sx(u(w[31]) * 4096 + u(w[7]) * 2048 + u(w[30:25]) * 32 + u(w[11:8]) * 2, 13); end
                7'h37, 7'h17: begin f = 4; v = sx(u(w[31:12]) * 4096, 32); end
                7'h6f: begin f = 5; v = sx(u(w[31]) * (1 << 20) + u(w[19:12]) * 4096 + u(w[20]) * 2048 + u(w[30:21]) * 2, 21); end
                7'h73: begin f = w[14] ? 6 : 1; v = w[14] ? u(w[19:15]) : i_imm; end
                default: ;
            endcase
        end else if (en_c) begin
            e.isc = 1'b1;
            if (w[15:0] != 16'h0) begin
                case ({w[15:13], w[1:0]})
                    5'b000_01, 5'b010_01: begin f = 1; v = sx(u(w[12]) * 32 + u(w[6:2]), 6); end
                    5'b011_01: if (w[11:7] != 0 && w[11:7] != 2) begin f = 4; v = sx(u(w[12]) * 32 + u(w[6:2]), 6) * 4096; end
                    5'b101_01: begin f = 5; v = sx(u(w[12]) * 2048 + u(w[8]) * 1024 + u(w[10:9]) * 256 + u(w[6]) * 128 +
                                              u(w[7]) * 64 + u(w[2]) * 32 + u(w[11]) * 16 + u(w[5:3]) * 2, 12); end
                    5'b110_01, 5'b111_01: begin f = 3; v = sx(u(w[12]) * 256 + u(w[6:5]) * 64 + u(w[2]) * 32 +
                                                          u(w[11:10]) * 8 + u(w[4:3]) * 2, 9); end
                    5'b010_00, 5'b110_00: begin f = w[15] ? 2 : 1; v = u(w[5]) * 64 + u(w[12:10]) * 8 + u(w[6]) * 4; end
                    default: ;
                endcase
            end
        end
        e.fmt = 3'(f);
        e.ill = (f == 0);
        e.imm = x64 ? 64'(v) : {32'b0, 32'(v)};
        return e;
    endfunction

    task automatic check_outputs();
        exp_t ea, eb;
        chk("a_ready", a_ready, q.size() < 2);
        chk("b_ready", b_ready, q.size() < 2);
        chk("a_valid", a_valid, q.size() > 0);
        chk("b_valid", b_valid, q.size() > 0);
        if (q.size() > 0) begin
            ea = ref_dec(q[0], 1'b0, 1'b1);
            eb = ref_dec(q[0], 1'b1, 1'b0);
            chk("a_instr", a_instr, q[0]);
            chk("a_imm", a_imm, ea.imm);
            chk("a_fmt", a_fmt, ea.fmt);
            chk("a_isc", a_isc, ea.isc);
            chk("a_ill", a_ill, ea.ill);
            chk("b_instr", b_instr, q[0]);
            chk("b_imm", b_imm, eb.imm);
            chk("b_fmt", b_fmt, eb.fmt);
            chk("b_isc", b_isc, eb.isc);
            chk("b_ill", b_ill, eb.ill);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] w, input bit r, input bit f);
        bit push, pop;
        in_valid = v; in_instr = w; out_ready = r; flush = f;
        @(negedge clk);
        check_outputs();
        push = v && q.size() < 2;
        pop  = q.size() > 0 && r;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(w);
        end
        #1;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_a_outs"}, {a_instr, a_imm, a_fmt, a_isc, a_ill}, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_b_outs"}, {b_instr, b_imm[31:0], b_fmt, b_isc, b_ill}, 0);
        chk({tag, "_b_imm_hi"}, b_imm[63:32], 0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk({tag, "_ready_pre_edge"}, a_ready, 0);
        @(posedge clk);
        #1 chk({tag, "_ready_post_edge"}, a_ready, 1);
        chk({tag, "_valid_post_edge"}, a_valid, 0);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops[10] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 15);
        if (k < 10) w[6:0] = ops[k];
        else if (k == 10) w[15:0] = 16'h0;
        else if (k > 11) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        #2 check_reset_zero("rst0");
        release_reset("rst0");
        step(1, 32'hFFF00093, 1, 0);
        chk("addi_latency_valid", a_valid, 1);
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_fmt", a_fmt, 1);
        chk("addi_ill", a_ill, 0);
        step(1, 32'hFE000EE3, 1, 0);
        chk("beq_fmt", a_fmt, 3);
        chk("beq_imm", a_imm, 32'hFFFFFFFC);
        step(1, 32'h0010006F, 1, 0);
        chk("jal_fmt", a_fmt, 5);
        chk("jal_imm", a_imm, 32'h00000800);
        step(1, 32'h800000B7, 1, 0);
        chk("lui64_fmt", b_fmt, 4);
        chk("lui64_imm", b_imm, 64'hFFFFFFFF80000000);
        chk("lui32_imm", a_imm, 32'h80000000);
        step(1, 32'h000050FD, 1, 0);
        chk("cli_isc", a_isc, 1);
        chk("cli_fmt", a_fmt, 1);
        chk("cli_imm", a_imm, 32'hFFFFFFFF);
        chk("cli_noc_ill", b_ill, 1);
        chk("cli_noc_fmt", b_fmt, 0);
        chk("cli_noc_imm", b_imm, 0);
        step(0, 0, 1, 0);
        step(1, 32'hAAAA0013, 0, 0);
        step(1, 32'hBBBB0013, 0, 0);
        chk("bp_full_ready", a_ready, 0);
        chk("bp_head_a", a_instr, 32'hAAAA0013);
        step(1, 32'hCCCC0013, 0, 0);
        chk("bp_stall_hold", a_instr, 32'hAAAA0013);
        step(1, 32'hCCCC0013, 1, 0);
        chk("bp_order_b", a_instr, 32'hBBBB0013);
        step(1, 32'hCCCC0013, 1, 0);
        chk("bp_order_c", a_instr, 32'hCCCC0013);
        step(0, 0, 1, 0);
        chk("bp_drained", a_valid, 0);
        step(1, 32'h00100013, 0, 0);
        step(1, 32'h00200013, 0, 0);
        step(1, 32'h00300013, 0, 1);
        chk("flush_valid", a_valid, 0);
        chk("flush_ready", a_ready, 1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        step(1, rnd_instr(), 0, 0);
        step(1, rnd_instr(), 0, 0);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_zero("rst_mid");
        q.delete();
        release_reset("rst_mid");
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 1) != 0, rnd_instr(), $urandom_range(0, 2) != 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter ENABLE_C, default 0; 1 enables decoding of the compressed (RVC) immediate subset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  an instruction is presented.
REQ-007 SHALL have port in_ready  output  1  the block accepts the instruction this cycle.
REQ-008 SHALL have port in_instr  input  32  instruction word; compressed instructions use bits [15:0].
REQ-009 SHALL have port out_valid  output  1  the output entry is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the output entry.
REQ-011 SHALL have port out_instr  output  32  the accepted instruction, passed through unchanged.
REQ-012 SHALL have port out_imm  output  XLEN  the decoded immediate.
REQ-013 SHALL have port out_fmt  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm.
REQ-014 SHALL have port out_is_c  output  1  the entry was a compressed instruction.
REQ-015 SHALL have port out_illegal  output  1  the opcode is unsupported.

Function
REQ-016 SHALL decode the immediate combinationally at the input and register the result with its entry, giving 1-cycle latency from acceptance to out_valid when the buffer is empty.
REQ-017 SHALL buffer entries in a 2-entry skid FIFO with states EMPTY, ONE and FULL.
REQ-018 SHALL drive in_ready = (state != FULL) from a register, with no combinational path from out_ready.
REQ-019 SHALL accept an instruction on in_valid && in_ready and pop an entry on out_valid && out_ready.
REQ-020 SHALL make transitions EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-021 SHALL handle simultaneous push and pop in state ONE with no bubble and no loss.
REQ-022 SHALL deliver entries in strict acceptance order.
REQ-023 SHALL hold all out_* signals stable while out_valid && !out_ready.
REQ-024 SHALL, on a 32-bit instruction (in_instr[1:0]==11), produce out_imm and out_fmt by opcode:
- I-type for 0010011, 0000011 and 1100111, {instr[31:20]} sign-extended;
- I-type for 0011011 when XLEN=64;
- S-type for 0100011;
- B-type for 1100011, {instr[31], instr[7], instr[30:25], instr[11:8], 0};
- U-type for 0110111 and 0010111, {instr[31:12], 12'b0};
- J-type for 1101111, {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-025 SHALL, on opcode 1110011, output fmt 6 with zimm = instr[19:15] zero-extended when funct3[2]=1, and otherwise fmt 1 with the I-type immediate.
REQ-026 SHALL sign-extend every signed immediate from its top bit to XLEN; when XLEN=64, U-type SHALL sign-extend from bit 31.
REQ-027 SHALL, when ENABLE_C=1 and in_instr[1:0]!=11, set out_is_c=1 and decode:
- C.ADDI/C.LI (q1, f3 000/010): fmt 1, sext({i[12], i[6:2]});
- C.LUI (q1, f3 011, rd not 0 or 2): fmt 4, sext({i[12], i[6:2]})<<12;
- C.J (q1, f3 101): fmt 5, sext({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 0});
- C.BEQZ/C.BNEZ (q1, f3 110/111): fmt 3, sext({i[12], i[6:5], i[2], i[11:10], i[4:3], 0});
- C.LW/C.SW (q0, f3 010/110): fmt 1/2, zext({i[5], i[12:10], i[6], 00}).
REQ-028 SHALL, for any other opcode, for in_instr[15:0]==0, for a compressed instruction outside the subset, or for in_instr[1:0]!=11 with ENABLE_C=0, output out_fmt=0, out_imm=0 and out_illegal=1, and SHALL still enqueue the entry.
REQ-029 SHALL, on flush=1, go to EMPTY at the next edge with out_valid=0, ignoring any same-cycle push; in_ready SHALL be 1 in the following cycle.

Reset
REQ-030 SHALL, when rst_n=0, immediately force state EMPTY, out_valid=0, in_ready=0, and out_imm, out_instr, out_fmt, out_is_c and out_illegal all 0.
REQ-031 SHALL drive in_ready=1 on the first clk edge after rst_n deasserts; an entry in flight when reset asserts SHALL be lost without a partial output.

Verification
REQ-032 SHALL cover: XLEN=32, 0xFFF00093 -> fmt 1, imm 0xFFFFFFFF, illegal 0, out_valid one cycle after acceptance.
REQ-033 SHALL cover: 0xFE000EE3 -> fmt 3, imm 0xFFFFFFFC; and 0x0010006F -> fmt 5, imm 0x00000800.
REQ-034 SHALL cover: XLEN=64, 0x800000B7 -> fmt 4, imm 0xFFFFFFFF80000000.
REQ-035 SHALL cover: ENABLE_C=1, 0x50FD -> is_c 1, fmt 1, imm 0xFFFFFFFF; and ENABLE_C=0, same word -> illegal 1, fmt 0, imm 0.
REQ-036 SHALL cover: out_ready=0 with three pushes A, B, C -> A and B accepted, in_ready=0 during C, then out_ready=1 -> A, B, C in order with no duplicates.
REQ-037 SHALL cover: FULL state plus flush -> out_valid=0 next cycle; then rst_n pulsed asynchronously mid-burst -> all outputs 0 immediately.
